// File: rtl/commit_order_arbiter.sv
// rtl/commit_order_arbiter.sv - merges out-of-order branch results into one writeback stream in commit_id order
module commit_order_arbiter #(
  parameter int data_width      = 16,
  parameter int n_branches      = 4,
  parameter int commit_id_width = 8,
  parameter int n_blocks        = 256,
  parameter int stall_limit     = 1023,
  localparam int bw = $clog2(n_blocks),
  localparam int sw = $clog2(n_branches),
  localparam int cw = $clog2(stall_limit + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [n_branches-1:0]                 in_valid,
  output logic [n_branches-1:0]                 in_ready,
  input  logic [n_branches*commit_id_width-1:0] in_commit_id,
  input  logic [n_branches*data_width-1:0]      in_data,
  input  logic [n_branches*4-1:0]               in_dest,
  input  logic [n_branches*bw-1:0]              in_block,
  input  logic [n_branches-1:0]                 in_writes_external,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [commit_id_width-1:0]            out_commit_id,
  output logic [data_width-1:0]                 out_data,
  output logic [3:0]                            out_dest,
  output logic [bw-1:0]                         out_block,
  output logic                                  out_writes_external,
  output logic [sw-1:0]                         out_branch,
  output logic [commit_id_width-1:0]            next_id,
  output logic                                  stall_error
);

  logic [n_branches-1:0] match;
  logic [n_branches-1:0] grant;
  logic [sw-1:0]         sel;
  logic                  found;
  logic                  free;
  logic                  accept;
  logic [cw-1:0]         stall_cnt;

  // Lowest-index match wins; extra matches are a protocol violation and simply wait.
  always_comb begin
    match = '0;
    grant = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < n_branches; i++) begin
      match[i] = in_valid[i] &&
                 (in_commit_id[i*commit_id_width +: commit_id_width] == next_id);
      if (match[i] && !found) begin
        grant[i] = 1'b1;
        sel      = sw'(i);
        found    = 1'b1;
      end
    end
  end

  assign free     = !out_valid || out_ready;
  assign in_ready = (enable && free) ? grant : '0;
  assign accept   = |in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid           <= 1'b0;
      out_commit_id       <= '0;
      out_data            <= '0;
      out_dest            <= '0;
      out_block           <= '0;
      out_writes_external <= 1'b0;
      out_branch          <= '0;
      next_id             <= '0;
      stall_cnt           <= '0;
      stall_error         <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        out_valid           <= 1'b1;
        out_commit_id       <= in_commit_id[int'(sel)*commit_id_width +: commit_id_width];
        out_data            <= in_data[int'(sel)*data_width +: data_width];
        out_dest            <= in_dest[int'(sel)*4 +: 4];
        out_block           <= in_block[int'(sel)*bw +: bw];
        out_writes_external <= in_writes_external[sel];
        out_branch          <= sel;
        next_id             <= next_id + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Watchdog: results waiting but none carries the expected ID.
      if (accept || in_valid == '0) begin
        stall_cnt <= '0;
      end else if (!(|match) && stall_cnt != cw'(stall_limit)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (stall_cnt == cw'(stall_limit)) begin
        stall_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_order_arbiter.sv
// tb/tb_commit_order_arbiter.sv - scoreboard bench for commit_order_arbiter
module tb_commit_order_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_commit_id;
  logic [63:0] in_data;
  logic [15:0] in_dest;
  logic [31:0] in_block;
  logic [3:0]  in_writes_external;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_commit_id;
  logic [15:0] out_data;
  logic [3:0]  out_dest;
  logic [7:0]  out_block;
  logic        out_writes_external;
  logic [1:0]  out_branch;
  logic [7:0]  next_id;
  logic        stall_error;

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] sb[$];

  commit_order_arbiter #(
    .data_width(16), .n_branches(4), .commit_id_width(8), .n_blocks(256), .stall_limit(7)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_commit_id(in_commit_id),
    .in_data(in_data), .in_dest(in_dest), .in_block(in_block),
    .in_writes_external(in_writes_external),
    .out_valid(out_valid), .out_ready(out_ready), .out_commit_id(out_commit_id),
    .out_data(out_data), .out_dest(out_dest), .out_block(out_block),
    .out_writes_external(out_writes_external), .out_branch(out_branch),
    .next_id(next_id), .stall_error(stall_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rec(int b, int id, logic [15:0] d);
    logic [7:0] idb;
    idb = 8'(id);
    return {25'd0, idb, d, d[3:0] ^ 4'(b), idb ^ 8'h5a, d[0] ^ idb[0], 2'(b)};
  endfunction

  task automatic present(int b, int id, logic [15:0] d);
    logic [7:0] idb;
    idb = 8'(id);
    in_valid[b]              = 1'b1;
    in_commit_id[b*8 +: 8]   = idb;
    in_data[b*16 +: 16]      = d;
    in_dest[b*4 +: 4]        = d[3:0] ^ 4'(b);
    in_block[b*8 +: 8]       = idb ^ 8'h5a;
    in_writes_external[b]    = d[0] ^ idb[0];
  endtask

  // One clock: branches whose result was taken at this edge drop valid afterwards.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #2;
    in_valid = in_valid & ~acc;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    in_valid = '0;
    sb.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
  endtask

  // Writeback monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!reset && enable && out_valid && out_ready) begin
      if (sb.size() == 0)
        check_eq("unexpected_out", 64'(out_commit_id), 64'hdead);
      else
        check_eq("out_rec",
                 {25'd0, out_commit_id, out_data, out_dest, out_block, out_writes_external, out_branch},
                 sb.pop_front());
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_commit_id = '0; in_data = '0; in_dest = '0;
    in_block = '0; in_writes_external = '0;
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_next_id", 64'(next_id), 0);
    check_eq("rst_stall_error", 64'(stall_error), 0);
    check_eq("rst_out_data", 64'(out_data), 0);
    @(posedge clk); #2; reset = 1'b0;
    @(posedge clk); #2;
    check_eq("post_rst_out_valid", 64'(out_valid), 0);
    check_eq("post_rst_next_id", 64'(next_id), 0);

    // In-order single branch
    for (int i = 0; i < 3; i++) begin
      present(0, i, 16'hA000 + 16'(i));
      sb.push_back(rec(0, i, 16'hA000 + 16'(i)));
      #1 check_eq("s1_in_ready", 64'(in_ready), 64'b0001);
      tick();
      check_eq("s1_out_valid", 64'(out_valid), 1);
      check_eq("s1_out_id", 64'(out_commit_id), 64'(i));
    end
    check_eq("s1_next_id", 64'(next_id), 3);
    check_eq("s1_out_branch", 64'(out_branch), 0);
    tick();
    check_eq("s1_drain", 64'(out_valid), 0);

    // Out-of-order completion
    do_reset();
    present(2, 1, 16'h1111);
    sb.push_back(rec(1, 0, 16'h0000));
    sb.push_back(rec(2, 1, 16'h1111));
    repeat (3) begin
      #1 check_eq("s2_wait_ready", 64'(in_ready), 0);
      tick();
    end
    present(1, 0, 16'h0000);
    #1 check_eq("s2_ready_b1", 64'(in_ready), 64'b0010);
    tick();
    check_eq("s2_branch1", 64'(out_branch), 1);
    check_eq("s2_ready_b2", 64'(in_ready), 64'b0100);
    tick();
    check_eq("s2_id1", 64'(out_commit_id), 1);
    check_eq("s2_branch2", 64'(out_branch), 2);
    tick();

    // Backpressure
    present(0, 2, 16'h2222);
    sb.push_back(rec(0, 2, 16'h2222));
    tick();
    out_ready = 1'b0;
    present(3, 3, 16'h3333);
    sb.push_back(rec(3, 3, 16'h3333));
    repeat (5) begin
      #1 check_eq("s3_ready_blocked", 64'(in_ready), 0);
      check_eq("s3_hold_id", 64'(out_commit_id), 2);
      check_eq("s3_hold_data", 64'(out_data), 64'h2222);
      check_eq("s3_hold_valid", 64'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    #1 check_eq("s3_ready_resume", 64'(in_ready), 64'b1000);
    tick();
    check_eq("s3_replaced_id", 64'(out_commit_id), 3);
    check_eq("s3_replaced_valid", 64'(out_valid), 1);
    tick();

    // Watchdog, next_id is 4 here
    present(3, 5, 16'h5555);
    repeat (7) tick();
    check_eq("s4_no_err_yet", 64'(stall_error), 0);
    tick();
    check_eq("s4_err_set", 64'(stall_error), 1);
    present(0, 4, 16'h4444);
    sb.push_back(rec(0, 4, 16'h4444));
    sb.push_back(rec(3, 5, 16'h5555));
    tick();
    tick();
    check_eq("s4_err_sticky", 64'(stall_error), 1);
    check_eq("s4_next_id", 64'(next_id), 6);
    tick();

    // Enable low freezes, then asynchronous reset mid-cycle
    out_ready = 1'b0;
    present(0, 6, 16'h6666);
    tick();
    check_eq("s6_loaded", 64'(out_valid), 1);
    enable = 1'b0;
    out_ready = 1'b1;
    present(1, 7, 16'h7777);
    #1 check_eq("s6_ready_off", 64'(in_ready), 0);
    repeat (3) tick();
    check_eq("s6_hold_valid", 64'(out_valid), 1);
    check_eq("s6_hold_id", 64'(out_commit_id), 6);
    check_eq("s6_hold_next", 64'(next_id), 7);
    check_eq("s6_hold_err", 64'(stall_error), 1);
    #1 reset = 1'b1;
    #1;
    check_eq("s6_async_valid", 64'(out_valid), 0);
    check_eq("s6_async_next", 64'(next_id), 0);
    check_eq("s6_async_err", 64'(stall_error), 0);
    check_eq("s6_async_id", 64'(out_commit_id), 0);
    in_valid = '0;
    enable = 1'b1;
    @(posedge clk); #2; reset = 1'b0; #1;

    // Wrap-around of commit IDs
    for (int i = 0; i < 255; i++) begin
      present(i % 4, i, 16'(i * 3 + 7));
      sb.push_back(rec(i % 4, i, 16'(i * 3 + 7)));
      tick();
    end
    check_eq("s5_pre_wrap", 64'(next_id), 255);
    present(1, 255, 16'hBEEF);
    present(2, 0, 16'hCAFE);
    sb.push_back(rec(1, 255, 16'hBEEF));
    sb.push_back(rec(2, 0, 16'hCAFE));
    #1 check_eq("s5_ready_255", 64'(in_ready), 64'b0010);
    tick();
    check_eq("s5_ready_0", 64'(in_ready), 64'b0100);
    tick();
    check_eq("s5_next_id", 64'(next_id), 1);
    check_eq("s5_out_id", 64'(out_commit_id), 0);
    tick();
    check_eq("s5_drain", 64'(out_valid), 0);
    check_eq("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
